// File: rtl/bramac_inst_gen_2sa.sv
// bramac_inst_gen_2sa: per-cycle BrAMAC 2-SA instruction sequencer; `define BRAMAC_INSTGEN_PERF_EN adds perf_cycles/perf_stall counters
module bramac_inst_gen_2sa #(
    parameter int DWIDTH = 40,
    parameter int READOUT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset_bram,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [1:0]        job_prec,
    input  logic              job_intype,
    input  logic [6:0]        job_num_mac,
    input  logic [6:0]        job_row,
    input  logic [1:0]        job_col,
    input  logic              act_valid,
    output logic              act_ready,
    input  logic [15:0]       act_data,
    output logic [DWIDTH-1:0] inst,
    output logic              comp_en,
    output logic              busy,
    output logic              job_done,
    output logic              job_err
`ifdef BRAMAC_INSTGEN_PERF_EN
    ,
    output logic [15:0]       perf_cycles,
    output logic [7:0]        perf_stall
`endif
);
    typedef enum logic [2:0] {IDLE, WAIT, START, INIT_W1, INIT_W2, RUN, DRAIN, RST} state_t;
    state_t state;
    logic [1:0] prec, col, cnt;
    logic intype, ur, rd, wr, push, pop, pop_slot, last, copy_nxt, illegal;
    logic [6:0] num_mac, row0, k, nxt_k, copy_row;
    logic [3:0] c, nxt_c, len, dcnt;
    logic [15:0] fifo [2];
    logic [15:0] pop_data;
    function automatic logic [DWIDTH-1:0] mk(input logic [1:0] p, input logic t, input logic [3:0] ctl,
                                             input logic [6:0] r, input logic [1:0] cl, input logic [15:0] d);
        mk = '0;
        mk[31:0] = {d, cl, r, ctl, t, p};
    endfunction
    always_comb begin
        len = (prec == 2'b01 ? 4'd2 : prec == 2'b10 ? 4'd4 : 4'd8) + 4'd2 + {3'd0, intype};
        last = c == len - 4'd1 && k == num_mac - 7'd1;
        nxt_c = c == len - 4'd1 ? 4'd0 : c + 4'd1;
        nxt_k = c == len - 4'd1 ? k + 7'd1 : k;
        copy_nxt = state == RUN && !last && nxt_c >= len - 4'd2 && nxt_k < num_mac - 7'd1;
        pop_slot = state == START || state == INIT_W1 || copy_nxt;
        pop = pop_slot && cnt != 2'd0;
        push = act_valid && act_ready;
        pop_data = cnt != 2'd0 ? fifo[rd] : 16'd0;
        copy_row = row0 + {nxt_k[5:0], 1'b0} + 7'd2 + {6'd0, nxt_c == len - 4'd1};
        illegal = job_prec == 2'b00 || job_num_mac == 7'd0 || job_num_mac > 7'd64;
    end
    assign job_ready = state == IDLE;
    assign act_ready = cnt != 2'd2;
    always_ff @(posedge clk) begin
        if (reset_bram) begin
            state <= IDLE;
            inst <= '0;
            comp_en <= 1'b0;
            busy <= 1'b0;
            job_done <= 1'b0;
            job_err <= 1'b0;
            cnt <= 2'd0;
            rd <= 1'b0;
            wr <= 1'b0;
            ur <= 1'b0;
            prec <= 2'b00;
            intype <= 1'b0;
            num_mac <= 7'd0;
            c <= 4'd0;
            k <= 7'd0;
            dcnt <= 4'd0;
        end else begin
            if (push) begin
                fifo[wr] <= act_data;
                wr <= ~wr;
            end
            if (pop) rd <= ~rd;
            cnt <= cnt + 2'(push) - 2'(pop);
            job_done <= 1'b0;
            job_err <= 1'b0;
            case (state)
                IDLE: if (job_valid) begin
                    if (illegal) begin
                        job_done <= 1'b1;
                        job_err <= 1'b1;
                    end else begin
                        prec <= job_prec;
                        intype <= job_intype;
                        num_mac <= job_num_mac;
                        row0 <= job_row;
                        col <= job_col;
                        k <= 7'd0;
                        ur <= 1'b0;
                        busy <= 1'b1;
                        inst <= mk(job_prec, job_intype, 4'b0000, 7'd0, 2'd0, 16'd0);
                        state <= WAIT;
                    end
                end
                WAIT: if (cnt == 2'd2) begin
                    comp_en <= 1'b1;
                    inst <= mk(prec, intype, 4'b0010, 7'd0, 2'd0, 16'd0);
                    state <= START;
                end
                START: begin
                    inst <= mk(prec, intype, 4'b0000, row0, col, pop_data);
                    state <= INIT_W1;
                end
                INIT_W1: begin
                    inst <= mk(prec, intype, 4'b0000, row0 + 7'd1, col, pop_data);
                    state <= INIT_W2;
                end
                INIT_W2: begin
                    c <= 4'd0;
                    inst <= mk(prec, intype, 4'b0000, 7'd0, 2'd0, 16'd0);
                    state <= RUN;
                end
                RUN: if (last) begin
                    dcnt <= 4'd0;
                    inst <= mk(prec, intype, 4'b0000, 7'd0, 2'd0, 16'd0);
                    state <= DRAIN;
                end else begin
                    c <= nxt_c;
                    k <= nxt_k;
                    ur <= ur | (copy_nxt && cnt == 2'd0);
                    inst <= mk(prec, intype, {nxt_c == len - 4'd1 && nxt_k == num_mac - 7'd1, copy_nxt, 2'b00},
                               copy_nxt ? copy_row : 7'd0, copy_nxt ? col : 2'd0, copy_nxt ? pop_data : 16'd0);
                end
                DRAIN: if (dcnt == 4'(READOUT_CYCLES - 1)) begin
                    inst <= mk(prec, intype, 4'b0001, 7'd0, 2'd0, 16'd0);
                    state <= RST;
                end else begin
                    dcnt <= dcnt + 4'd1;
                end
                RST: begin
                    inst <= '0;
                    comp_en <= 1'b0;
                    busy <= 1'b0;
                    job_done <= 1'b1;
                    job_err <= ur;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef BRAMAC_INSTGEN_PERF_EN
    always_ff @(posedge clk) begin
        if (reset_bram || (state == IDLE && job_valid)) begin
            perf_cycles <= 16'd0;
            perf_stall <= 8'd0;
        end else begin
            if (comp_en && perf_cycles != 16'hFFFF) perf_cycles <= perf_cycles + 16'd1;
            if (state == WAIT && perf_stall != 8'hFF) perf_stall <= perf_stall + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_bramac_inst_gen_2sa.sv
// tb_bramac_inst_gen_2sa: randomized bench against a schedule-list reference model of the sequencer
module tb_bramac_inst_gen_2sa;
    localparam int RO = 2;
    logic clk = 1'b0, reset_bram, job_valid, job_ready, job_intype, act_valid, act_ready;
    logic comp_en, busy, job_done, job_err;
    logic [1:0] job_prec, job_col;
    logic [6:0] job_num_mac, job_row;
    logic [15:0] act_data;
    logic [39:0] inst;
`ifdef BRAMAC_INSTGEN_PERF_EN
    logic [15:0] perf_cycles;
    logic [7:0] perf_stall;
`endif
    bramac_inst_gen_2sa #(.DWIDTH(40), .READOUT_CYCLES(RO)) dut (
        .clk(clk), .reset_bram(reset_bram), .job_valid(job_valid), .job_ready(job_ready),
        .job_prec(job_prec), .job_intype(job_intype), .job_num_mac(job_num_mac), .job_row(job_row),
        .job_col(job_col), .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
        .inst(inst), .comp_en(comp_en), .busy(busy), .job_done(job_done), .job_err(job_err)
`ifdef BRAMAC_INSTGEN_PERF_EN
        , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
    );
    always #5 clk = ~clk;
    int n_cmp = 0, n_err = 0;
    typedef struct {int kind; int k; int c;} slot_t;
    slot_t sched[$];
    logic [15:0] q[$];
    logic [15:0] src[$];
    int ph = 0, pos = 0, mp, mt, mn, mrow, mcol, mur, act_pct = 100;
    bit m_acc, m_push;
    longint e_inst = 0;
    bit e_comp = 0, e_busy = 0, e_done = 0, e_err = 0;
    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask
    function automatic longint mk_e(int p, int t, int rs, int st, int cp, int dn, int row, int col, longint d);
        return p + t * 4 + rs * 8 + st * 16 + cp * 32 + dn * 64 + (row % 128) * 128 + col * 16384 + d * 65536;
    endfunction
    task automatic popq(output longint d);
        if (q.size() == 0) begin
            mur = 1;
            d = 0;
        end else d = q.pop_front();
    endtask
    task automatic eval_slot(slot_t s);
        int len;
        longint d;
        len = (mp == 1 ? 2 : mp == 2 ? 4 : 8) + 2 + mt;
        case (s.kind)
            0: e_inst = mk_e(mp, mt, 0, 1, 0, 0, 0, 0, 0);
            1: begin popq(d); e_inst = mk_e(mp, mt, 0, 0, 0, 0, mrow, mcol, d); end
            2: begin popq(d); e_inst = mk_e(mp, mt, 0, 0, 0, 0, mrow + 1, mcol, d); end
            3: if (s.c >= len - 2 && s.k < mn - 1) begin
                popq(d);
                e_inst = mk_e(mp, mt, 0, 0, 1, 0, mrow + 2 * (s.k + 1) + (s.c - (len - 2)), mcol, d);
            end else e_inst = mk_e(mp, mt, 0, 0, 0, (s.c == len - 1 && s.k == mn - 1) ? 1 : 0, 0, 0, 0);
            4: e_inst = mk_e(mp, mt, 0, 0, 0, 0, 0, 0, 0);
            default: e_inst = mk_e(mp, mt, 1, 0, 0, 0, 0, 0, 0);
        endcase
    endtask
    task automatic model_edge();
        logic [15:0] pd;
        int len;
        m_push = act_valid && q.size() < 2;
        pd = act_data;
        m_acc = 0;
        e_done = 0;
        e_err = 0;
        if (reset_bram) begin
            ph = 0;
            q.delete();
            e_inst = 0;
            e_comp = 0;
            e_busy = 0;
            m_push = 0;
            return;
        end
        case (ph)
            0: if (job_valid) begin
                m_acc = 1;
                if (job_prec == 0 || job_num_mac == 0 || job_num_mac > 64) begin
                    e_done = 1;
                    e_err = 1;
                end else begin
                    mp = job_prec; mt = job_intype; mn = job_num_mac; mrow = job_row; mcol = job_col;
                    mur = 0;
                    ph = 1;
                    e_busy = 1;
                    e_inst = mk_e(mp, mt, 0, 0, 0, 0, 0, 0, 0);
                end
            end
            1: if (q.size() == 2) begin
                len = (mp == 1 ? 2 : mp == 2 ? 4 : 8) + 2 + mt;
                sched.delete();
                for (int i = 0; i < 3; i++) sched.push_back('{i, 0, 0});
                for (int kk = 0; kk < mn; kk++)
                    for (int cc = 0; cc < len; cc++) sched.push_back('{3, kk, cc});
                for (int i = 0; i < RO; i++) sched.push_back('{4, 0, 0});
                sched.push_back('{5, 0, 0});
                pos = 0;
                ph = 2;
                e_comp = 1;
                eval_slot(sched[0]);
            end
            default: begin
                pos++;
                if (pos == sched.size()) begin
                    ph = 0;
                    e_inst = 0;
                    e_comp = 0;
                    e_busy = 0;
                    e_done = 1;
                    e_err = mur != 0;
                end else eval_slot(sched[pos]);
            end
        endcase
        if (m_push) q.push_back(pd);
    endtask
    task automatic tick();
        act_valid = src.size() > 0 && $urandom_range(99) < act_pct;
        act_data = act_valid ? src[0] : 16'($urandom);
        model_edge();
        if (m_push) void'(src.pop_front());
        @(posedge clk);
        #1;
        check("inst", inst, e_inst);
        check("comp_en", comp_en, e_comp);
        check("busy", busy, e_busy);
        check("job_done", job_done, e_done);
        check("job_err", job_err, e_done ? e_err : 1'b0);
        check("job_ready", job_ready, ph == 0);
        check("act_ready", act_ready, q.size() < 2);
    endtask
    task automatic submit(int p, int t, int n, int row, int col);
        int g = 0;
        job_prec = 2'(p); job_intype = 1'(t); job_num_mac = 7'(n); job_row = 7'(row); job_col = 2'(col);
        job_valid = 1;
        do begin tick(); g++; end while (!m_acc && g < 2000);
        job_valid = 0;
        if (!m_acc) check("accept_timeout", 0, 1);
    endtask
    task automatic finish_job();
        int g = 0;
        while (ph != 0 && g < 3000) begin tick(); g++; end
        if (ph != 0) check("job_timeout", 64'(ph), 0);
    endtask
    task automatic fill(int n);
        for (int i = 0; i < n; i++) src.push_back(16'($urandom));
    endtask
    initial begin
        int lat, acc, g, r, n;
        reset_bram = 1; job_valid = 0; act_valid = 0; act_data = 0;
        job_prec = 0; job_intype = 0; job_num_mac = 0; job_row = 0; job_col = 0;
        tick(); tick();
        reset_bram = 0;
        tick();
        // 8b signed, one MAC, pre-filled FIFO: fixed 18-cycle latency
        src = '{16'h8001, 16'h7F02};
        tick(); tick();
        submit(3, 1, 1, 10, 2);
        lat = 0;
        while (!job_done && lat < 200) begin tick(); lat++; end
        check("t1_latency", lat, 18);
        check("t1_err", job_err, 0);
        // 2b unsigned, three MACs, rows wrap past 127
        for (int i = 0; i < 6; i++) src.push_back(16'h1111 * 16'(i + 1));
        submit(1, 0, 3, 126, 1);
        finish_job();
        // underrun: only the two init pairs are ever supplied
        src = '{16'hA5C3, 16'h3C5A};
        submit(2, 1, 2, 40, 3);
        finish_job();
        check("t3_err", job_err, 1);
        // illegal descriptors
        submit(0, 0, 4, 0, 0);
        submit(2, 0, 0, 0, 0);
        submit(3, 1, 65, 0, 0);
        tick();
        // reset in the middle of iteration 1
        fill(20);
        submit(1, 0, 3, 5, 0);
        g = 0;
        while (!(ph == 2 && sched[pos].kind == 3 && sched[pos].k == 1) && g < 500) begin tick(); g++; end
        check("t5_reached_k1", g < 500, 1);
        reset_bram = 1;
        tick();
        reset_bram = 0;
        src.delete();
        check("t5_busy", busy, 0);
        check("t5_act_ready", act_ready, 1);
        for (int i = 0; i < 4; i++) tick();
        // back-to-back: job_valid held across the first job
        fill(40);
        job_prec = 2; job_intype = 0; job_num_mac = 2; job_row = 100; job_col = 1;
        job_valid = 1;
        acc = 0; g = 0;
        while (acc < 2 && g < 1000) begin tick(); acc += m_acc; g++; end
        job_valid = 0;
        check("t6_two_accepts", acc, 2);
        finish_job();
        // randomized jobs
        for (int j = 0; j < 40; j++) begin
            r = $urandom_range(19);
            n = r == 0 ? 0 : r == 1 ? 64 : r == 2 ? 65 : 1 + r % 4;
            act_pct = $urandom_range(30, 100);
            fill((n >= 1 && n <= 64) ? ((2 * n - int'($urandom_range(2))) < 2 ? 2 : 2 * n - int'($urandom_range(2))) : 0);
            submit($urandom_range(3), $urandom_range(1), n, $urandom_range(127), $urandom_range(3));
            finish_job();
            if ($urandom_range(3) == 0) tick();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/bramac_inst_gen_2sa.md
Name: bramac_inst_gen_2sa

Overview:
- Instruction sequencer directly upstream of the 2-SA BrAMAC control FSM.
- Accepts a MAC job descriptor and a stream of 16-bit activation pairs.
- Emits one 40-bit BrAMAC instruction per cycle, timed to the FSM's fixed state schedule: start, weight init, per-iteration input reload and weight copy, done, readout, reset.
- Drives the M20K `comp_en` for the duration of the job.

Parameters:
- DWIDTH, 40, instruction width; must match the `DWIDTH` define.
- READOUT_CYCLES, 2, cycles held after done while the FSM reads out the accumulator (1..15).

Ports:
- clk  in  1  clock
- reset_bram  in  1  global synchronous active-high reset
- job_valid  in  1  job descriptor valid
- job_ready  out  1  job accepted when valid&ready
- job_prec  in  2  01=2b, 10=4b, 11=8b, 00=illegal
- job_intype  in  1  1=signed activations
- job_num_mac  in  7  iteration count, legal 1..64
- job_row  in  7  BRAM row of first W1
- job_col  in  2  BRAM column select
- act_valid  in  1  activation pair valid
- act_ready  out  1  activation pair accepted when valid&ready
- act_data  in  16  [7:0]=input_1, [15:8]=input_2
- inst  out  DWIDTH  instruction to FSM
- comp_en  out  1  compute mode enable
- busy  out  1  job in progress
- job_done  out  1  one-cycle pulse at job end
- job_err  out  1  qualifies job_done: illegal job or activation underrun

Behaviour:
- Reset: clk and reset_bram only; reset is synchronous, active-high.
  - State=IDLE; inst=0; comp_en=0; busy=0; job_done=0; job_err=0.
  - job_ready=1; act_ready=1; activation buffer emptied.
  - A mid-job reset abandons the job with no job_done; the FSM is reset by the same signal.
- Instruction fields: [1:0] prec, [2] intype, [3] reset, [4] start, [5] copy, [6] done, [13:7] row, [15:14] col, [23:16] input_1, [31:24] input_2, [39:32] 0.
  - prec/intype hold the latched job values in all non-IDLE states.
  - Unlisted fields are 0.
- Activation buffer: 2-entry FIFO, act_ready = not full. Each entry supplies input_1/input_2 for one dummy array.
- Iteration length: L = P + 2 + intype cycles, where P = 2/4/8 (e.g. 8b signed = 11, 2b unsigned = 4). Cycle index c counts 0..L-1 within an iteration.
- States:
  - IDLE:
    - job_ready=1.
    - On accept of an illegal job (prec=00 or num_mac=0 or >64): job_done=job_err=1 next cycle, stay IDLE.
    - On accept of a legal job: latch fields, iteration counter k=0, go WAIT.
  - WAIT: busy=1, comp_en=0, job_ready=0; when FIFO holds 2 entries, go START.
  - START: comp_en=1, start=1 for 1 cycle.
  - INIT_W1: pop entry → inputs; row=job_row.
  - INIT_W2: pop entry → inputs; row=job_row+1; go RUN with c=0.
  - RUN:
    - At c=L-2 (FSM in ADD) and c=L-1 (FSM in ACC), if k<num_mac-1: pop one entry each cycle into the inputs, copy=1, row=job_row+2(k+1) at ADD and +2(k+1)+1 at ACC.
    - If the FIFO is empty at such a pop: drive inputs 0 and set sticky underrun. The FSM is never stalled.
    - At c=L-1 with k=num_mac-1: done=1, go DRAIN. Otherwise k++ and c=0.
  - DRAIN: READOUT_CYCLES cycles, inst control bits 0.
  - RST: reset=1 for 1 cycle, then IDLE. job_done=1 the following cycle; job_err=underrun.
- Row arithmetic is modulo 128 and wraps silently.
- act_ready stays 1 whenever the FIFO is not full, including in IDLE.
- A simultaneous push and pop when full is illegal and cannot occur, because act_ready=0.
- Job latency from accept with a full FIFO: 1 (WAIT) + 3 + num_mac·L + READOUT_CYCLES + 1 cycles until job_done.

Optional Feature:
- Macro: BRAMAC_INSTGEN_PERF_EN.
- Defined:
  - Adds output perf_cycles[15:0], counting cycles with comp_en=1 for the last completed job (saturating at 0xFFFF).
  - Adds output perf_stall[7:0], counting WAIT cycles.
  - Both counters clear on job accept and are held after job_done.
- Undefined: neither port exists; no counters.

Test Plan:
- 8b signed, num_mac=1, row=10, FIFO pre-filled 0x8001, 0x7F02 → start at WAIT+1.
  - Inputs 0x01/0x80 at INIT_W1, 0x02/0x7F at INIT_W2.
  - done at RUN c=10.
  - 2 DRAIN cycles, reset pulse, job_done with err=0.
  - Total 1+3+11+2+1=18 cycles.
- 2b unsigned, num_mac=3, row=126, 6 pairs streamed one per cycle → L=4.
  - copy=1 with rows 0,1 (wrap) in iteration 0 ADD/ACC, then rows 2,3 in iteration 1.
  - done only on the last ACC.
- Underrun: 4b signed, num_mac=2, act_valid dropped after the first 2 pairs → ADD/ACC of iteration 0 carry zero inputs; job_done with job_err=1.
- Illegal job: prec=00 → no comp_en, job_done=job_err=1 one cycle after accept. Same for num_mac=0.
- Reset asserted mid-RUN at k=1 → next cycle inst=0, comp_en=0, busy=0, FIFO empty, no job_done.
- Back-to-back jobs: second job_valid held during the first → accepted only in IDLE after job_done; FIFO refill overlaps the first job's DRAIN.
